// File: rtl/acc_pack_pkg.sv
// rtl/acc_pack_pkg.sv - shared defaults, pixel limit and accumulator word type for acc_result_pack
package acc_pack_pkg;
  localparam int FRAC_BITS_DEF = 12;
  localparam int PACK_DEF      = 4;
  localparam int ACC_W         = 48;
  localparam int PIX_MAX       = 255;

  typedef logic signed [ACC_W-1:0] acc_word_t;

  function automatic logic [7:0] clamp_pix(input acc_word_t v);
    if (v < 0) return 8'd0;
    else if (v > acc_word_t'(PIX_MAX)) return 8'(PIX_MAX);
    else return v[7:0];
  endfunction
endpackage

// File: rtl/acc_pack_skid_fifo.sv
// rtl/acc_pack_skid_fifo.sv - 2-entry output FIFO; head register drives the output directly
module acc_pack_skid_fifo #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clken,
  input  logic         i_tvalid,
  input  logic [W-1:0] i_tdata,
  output logic         o_tvalid,
  output logic [W-1:0] o_tdata,
  input  logic         i_tready,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_q0;
  logic [W-1:0] r_q1;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop    = (r_count != 2'd0) && i_tready;
  // a full FIFO still takes a word when the head leaves in the same cycle
  assign w_push   = i_tvalid && ((r_count != 2'd2) || w_pop);
  assign o_tvalid = (r_count != 2'd0);
  assign o_tdata  = r_q0;
  assign o_count  = r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q0    <= '0;
      r_q1    <= '0;
      r_count <= 2'd0;
    end else if (i_clken) begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_q0 <= i_tdata;
          else                 r_q1 <= i_tdata;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_q0    <= r_q1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_q0 <= i_tdata;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= i_tdata;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/acc_result_pack.sv
// rtl/acc_result_pack.sv - shift, clamp and pack accumulator results into pixel words
// ACC_RESULT_PACK_ROUND_EN selects round-half-up instead of truncation.
module acc_result_pack
  import acc_pack_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int PACK      = PACK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic              s_valid,
  input  acc_word_t         s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              m_valid,
  output logic [8*PACK-1:0] m_data,
  output logic [PACK-1:0]   m_keep,
  output logic              m_last,
  input  logic              m_ready
);
  localparam int PW = 8 * PACK;
  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int FW = PW + PACK + 1;
  localparam logic [LW-1:0]   LANE_LAST = LW'(PACK - 1);
  localparam logic [PACK-1:0] KEEP_ONE  = PACK'(1);
`ifdef ACC_RESULT_PACK_ROUND_EN
  localparam acc_word_t ROUND_TERM = acc_word_t'(1) <<< (FRAC_BITS - 1);
`else
  localparam acc_word_t ROUND_TERM = '0;
`endif

  logic            r_up;
  logic [LW-1:0]   r_in_lane;
  logic            r_s1_valid, r_s1_last, r_s1_close;
  acc_word_t       r_s1_val;
  logic            r_s2_valid, r_s2_last, r_s2_close;
  logic [7:0]      r_s2_pix;
  logic [LW-1:0]   r_lane;
  logic [PW-1:0]   r_acc_data;
  logic [PACK-1:0] r_acc_keep;
  logic            r_w_valid, r_w_last;
  logic [PW-1:0]   r_w_data;
  logic [PACK-1:0] r_w_keep;

  logic            w_accept, w_in_close, w_pack_close;
  acc_word_t       w_sum;
  logic [1:0]      w_count;
  logic [2:0]      w_pending;
  logic [PW-1:0]   w_merged_data;
  logic [PACK-1:0] w_merged_keep;
  logic [FW-1:0]   w_fifo_out;

  // Input-side lane shadow predicts which pixels will close a word, so only
  // those need a FIFO credit before they are accepted.
  assign w_in_close = s_last || (r_in_lane == LANE_LAST);
  assign w_pending  = 3'(r_s1_valid & r_s1_close) + 3'(r_s2_valid & r_s2_close) + 3'(r_w_valid);
  assign s_ready    = r_up && (({1'b0, w_count} + w_pending) < 3'd2);
  assign w_accept   = s_valid && s_ready && clken;
  assign w_sum      = s_data + ROUND_TERM;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_up       <= 1'b0;
      r_in_lane  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_close <= 1'b0;
      r_s1_val   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_close <= 1'b0;
      r_s2_pix   <= 8'd0;
    end else if (clken) begin
      r_up       <= 1'b1;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_val   <= w_sum >>> FRAC_BITS;
        r_s1_last  <= s_last;
        r_s1_close <= w_in_close;
        r_in_lane  <= w_in_close ? '0 : r_in_lane + LW'(1);
      end
      r_s2_valid <= r_s1_valid;
      r_s2_pix   <= clamp_pix(r_s1_val);
      r_s2_last  <= r_s1_last;
      r_s2_close <= r_s1_close;
    end
  end

  assign w_pack_close  = r_s2_last || (r_lane == LANE_LAST);
  assign w_merged_data = r_acc_data | (PW'(r_s2_pix) << (8 * r_lane));
  assign w_merged_keep = r_acc_keep | (KEEP_ONE << r_lane);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane     <= '0;
      r_acc_data <= '0;
      r_acc_keep <= '0;
      r_w_valid  <= 1'b0;
      r_w_data   <= '0;
      r_w_keep   <= '0;
      r_w_last   <= 1'b0;
    end else if (clken) begin
      r_w_valid <= r_s2_valid && w_pack_close;
      if (r_s2_valid) begin
        if (w_pack_close) begin
          r_w_data   <= w_merged_data;
          r_w_keep   <= w_merged_keep;
          r_w_last   <= r_s2_last;
          r_acc_data <= '0;
          r_acc_keep <= '0;
          r_lane     <= '0;
        end else begin
          r_acc_data <= w_merged_data;
          r_acc_keep <= w_merged_keep;
          r_lane     <= r_lane + LW'(1);
        end
      end
    end
  end

  acc_pack_skid_fifo #(.W(FW)) u_fifo (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_clken  (clken),
    .i_tvalid (r_w_valid),
    .i_tdata  ({r_w_last, r_w_keep, r_w_data}),
    .o_tvalid (m_valid),
    .o_tdata  (w_fifo_out),
    .i_tready (m_ready),
    .o_count  (w_count)
  );

  assign {m_last, m_keep, m_data} = w_fifo_out;
endmodule

// File: tb/tb_acc_result_pack.sv
// tb/tb_acc_result_pack.sv - self-checking bench for acc_result_pack (FRAC_BITS=12, PACK=4)
module tb_acc_result_pack;
  logic        clk = 1'b0;
  logic        reset, clken, s_valid, s_last, s_ready;
  logic [47:0] s_data;
  logic        m_valid, m_last, m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} word_t;
  typedef struct {logic [47:0] data; logic last; logic [31:0] exp_d; logic [3:0] exp_k; logic exp_l;} vec_t;

  word_t exp_q[$];
  word_t got_log[$];
  word_t run_a[$];
  int    part[$];
  int    got_cnt = 0;
  word_t last_word;
  logic  prev_hold = 1'b0;
  word_t prev_w;

  acc_result_pack #(.FRAC_BITS(12), .PACK(4)) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Pixel value from the arithmetic rule: floor((x + round) / 2^12), clamped to 0..255.
  function automatic int ref_pix(input logic [47:0] d);
    longint x, q;
    x = longint'($signed(d));
`ifdef ACC_RESULT_PACK_ROUND_EN
    x = x + 2048;
`endif
    if (x >= 0) q = x / 4096;
    else q = -((-x + 4095) / 4096);
    if (q < 0) return 0;
    if (q > 255) return 255;
    return int'(q);
  endfunction

  function automatic void model_push(input int p, input logic last);
    word_t w;
    part.push_back(p);
    if (part.size() == 4 || last) begin
      w.d = 32'd0;
      foreach (part[i]) w.d = w.d | (32'(part[i]) << (8 * i));
      w.k = 4'((1 << part.size()) - 1);
      w.l = last;
      exp_q.push_back(w);
      part.delete();
    end
  endfunction

  always @(negedge clk) begin
    word_t w, e;
    if (reset) begin
      part.delete();
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      w = '{m_data, m_keep, m_last};
      if (prev_hold) begin
        check("hold_valid", m_valid, 1);
        check("hold_word", w, prev_w);
      end
      if (clken && s_valid && s_ready) model_push(ref_pix(s_data), s_last);
      if (clken && m_valid && m_ready) begin
        got_cnt++;
        got_log.push_back(w);
        last_word = w;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", w);
        end else begin
          e = exp_q.pop_front();
          check("word_order", w, e);
        end
      end
      prev_hold = m_valid && !(m_ready && clken);
      prev_w    = w;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [47:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 100) begin
      step();
      n++;
    end
    if (!s_ready) check("send_timeout", 0, 1);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!m_valid && n < 20) begin
      step();
      n++;
    end
    if (!m_valid) check("wait_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (3) step();
  endtask

  function automatic logic [47:0] rand_data();
    case ($urandom_range(0, 3))
      0: return 48'(longint'($urandom_range(0, 1300000)) - 100000);
      1: return {16'($urandom), 32'($urandom)};
      2: return 48'(longint'(255 * 4096) + longint'($urandom_range(0, 8191)) - 4096);
      default: return 48'(longint'($urandom_range(0, 8191)) - 4096);
    endcase
  endfunction

  initial begin
    vec_t  vecs[10];
    int    pat_pix[12];
    logic  pat_last[12];
    int    base, c, idx;
    logic  saw_stall;
    logic  [38:0] snap;

`ifdef ACC_RESULT_PACK_ROUND_EN
    vecs[0] = '{48'd6144,      1'b1, 32'd2,   4'h1, 1'b1};
    vecs[3] = '{48'd4095,      1'b1, 32'd1,   4'h1, 1'b1};
    vecs[7] = '{48'd2048,      1'b1, 32'd1,   4'h1, 1'b1};
`else
    vecs[0] = '{48'd6144,      1'b1, 32'd1,   4'h1, 1'b1};
    vecs[3] = '{48'd4095,      1'b1, 32'd0,   4'h1, 1'b1};
    vecs[7] = '{48'd2048,      1'b1, 32'd0,   4'h1, 1'b1};
`endif
    vecs[1] = '{-48'sd4096,    1'b1, 32'd0,   4'h1, 1'b1};
    vecs[2] = '{48'd1228800,   1'b1, 32'd255, 4'h1, 1'b1};
    vecs[4] = '{48'd1048575,   1'b1, 32'd255, 4'h1, 1'b1};
    vecs[5] = '{48'd1044480,   1'b1, 32'd255, 4'h1, 1'b1};
    vecs[6] = '{48'd2047,      1'b1, 32'd0,   4'h1, 1'b1};
    vecs[8] = '{48'd0,         1'b1, 32'd0,   4'h1, 1'b1};
    vecs[9] = '{-48'sd1,       1'b1, 32'd0,   4'h1, 1'b1};

    reset = 1'b1; clken = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) step();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_keep", m_keep, 0);
    check("rst_m_last", m_last, 0);
    check("rst_s_ready", s_ready, 0);
    reset = 1'b0;
    step();
    check("ready_after_reset", s_ready, 1);

    for (int i = 0; i < 10; i++) begin
      send_pix(vecs[i].data, vecs[i].last);
      wait_valid();
      check($sformatf("vec%0d_data", i), m_data, vecs[i].exp_d);
      check($sformatf("vec%0d_keep", i), m_keep, vecs[i].exp_k);
      check($sformatf("vec%0d_last", i), m_last, vecs[i].exp_l);
      step();
    end
    drain();

    for (int p = 1; p <= 4; p++) send_pix(48'(p * 4096), 1'b0);
    step();
    check("lat_c1_valid", m_valid, 0);
    step();
    check("lat_c2_valid", m_valid, 0);
    step();
    check("lat_c3_valid", m_valid, 1);
    check("w1234_data", m_data, 32'h04030201);
    check("w1234_keep", m_keep, 4'hF);
    check("w1234_last", m_last, 0);
    drain();

    send_pix(48'(7 * 4096), 1'b0);
    send_pix(48'(9 * 4096), 1'b1);
    wait_valid();
    check("w79_data", m_data, 32'h00000907);
    check("w79_keep", m_keep, 4'h3);
    check("w79_last", m_last, 1);
    step();
    for (int p = 10; p <= 13; p++) send_pix(48'(p * 4096), 1'b0);
    wait_valid();
    check("after_last_data", m_data, 32'h0D0C0B0A);
    check("after_last_keep", m_keep, 4'hF);
    drain();

    base = got_cnt; idx = 0; c = 0; saw_stall = 1'b0;
    s_valid = 1'b1; s_last = 1'b0; s_data = 48'(100);
    while (idx < 40 && c < 600) begin
      logic acc;
      m_ready = (c >= 10);
      if (!s_ready && c < 10) saw_stall = 1'b1;
      acc = s_ready;
      step();
      c++;
      if (acc) begin
        idx++;
        s_data = 48'(((idx * 7) % 256) * 4096 + 100);
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("bp_all_sent", idx, 40);
    check("bp_stalled", saw_stall, 1);
    drain();
    check("bp_word_count", got_cnt - base, 10);

    send_pix(48'(1 * 4096), 1'b0);
    send_pix(48'(2 * 4096), 1'b0);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    base = got_cnt;
    for (int p = 5; p <= 8; p++) send_pix(48'(p * 4096), 1'b0);
    drain();
    check("rst_partial_count", got_cnt - base, 1);
    check("rst_partial_word", last_word, {32'h08070605, 4'hF, 1'b0});

    for (int i = 0; i < 12; i++) begin
      pat_pix[i]  = (i * 37 + 11) % 256;
      pat_last[i] = (i == 1 || i == 6 || i == 11);
    end
    for (int run = 0; run < 2; run++) begin
      got_log.delete();
      for (int i = 0; i < 12; i++) begin
        send_pix(48'(pat_pix[i] * 4096 + 5), pat_last[i]);
        if (run == 1 && i == 3) begin
          clken = 1'b0;
          snap = {m_valid, m_data, m_keep, m_last, s_ready};
          for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("freeze_c%0d", k), {m_valid, m_data, m_keep, m_last, s_ready}, snap);
          end
          clken = 1'b1;
        end
      end
      drain();
      if (run == 0) run_a = got_log;
    end
    check("freeze_count", got_log.size(), run_a.size());
    for (int i = 0; i < run_a.size() && i < got_log.size(); i++)
      check($sformatf("freeze_word%0d", i), got_log[i], run_a[i]);

    for (int cyc = 0; cyc < 1500; cyc++) begin
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = rand_data();
      s_last  = ($urandom_range(0, 4) == 0);
      m_ready = ($urandom_range(0, 9) < 7);
      clken   = ($urandom_range(0, 9) < 9);
      step();
    end
    s_valid = 1'b0; s_last = 1'b0; clken = 1'b1; m_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
